// File: rtl/aes_key_rev_gen.sv
// Reverse AES key schedule: loaded with the last round key(s), walks back to rk0 one key per next pulse.
// Optional macro AES_KEY_REV_256_EN adds AES-256 support; without it the block is AES-128 only.
module aes_key_rev_gen (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [255:0] key,
    input  logic         keylen,
    input  logic         load,
    input  logic         next,
    output logic [127:0] round_key,
    output logic [3:0]   round,
    output logic         valid,
    output logic         done,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t       state_q, state_d;
    logic [127:0] hi_q, hi_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         done_q, done_d;

    logic [31:0]  b0, b1, b2, b3;
    logic [31:0]  c0, c1, c2, c3;
    logic [31:0]  rot_sub;
    logic [31:0]  rcon_w;

    // Inverse of the forward Rcon doubling in GF(2^8).
    function automatic logic [7:0] rcon_back(input logic [7:0] r);
        logic [7:0] t;
        t = r ^ (r[0] ? 8'h1b : 8'h00);
        return {r[0], t[7:1]};
    endfunction

    assign b0      = hi_q[127:96];
    assign b1      = hi_q[95:64];
    assign b2      = hi_q[63:32];
    assign b3      = hi_q[31:0];
    assign c3      = b3 ^ b2;
    assign c2      = b2 ^ b1;
    assign c1      = b1 ^ b0;
    assign rot_sub = {new_sboxw[23:0], new_sboxw[31:24]};
    assign rcon_w  = {rcon_q, 24'h0};

`ifdef AES_KEY_REV_256_EN
    logic [127:0] lo_q, lo_d;
    logic         len_q, len_d;
    logic         even_rnd;

    assign even_rnd = ~round_q[0];
    // AES-256 recovers its first word from the older half-key (lo); odd rounds skip RotWord/Rcon.
    assign sboxw    = len_q ? lo_q[31:0] : c3;
    assign c0       = (len_q && !even_rnd) ? (b0 ^ new_sboxw) : (b0 ^ rot_sub ^ rcon_w);
`else
    logic unused_inputs;

    assign unused_inputs = ^{keylen, key[127:0]};
    assign sboxw         = c3;
    assign c0            = b0 ^ rot_sub ^ rcon_w;
`endif

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
`ifdef AES_KEY_REV_256_EN
        lo_d    = lo_q;
        len_d   = len_q;
`endif
        if (load) begin
            state_d = ACTIVE;
            hi_d    = key[255:128];
`ifdef AES_KEY_REV_256_EN
            lo_d    = key[127:0];
            len_d   = keylen;
            round_d = keylen ? 4'd14 : 4'd10;
            rcon_d  = keylen ? 8'h40 : 8'h36;
`else
            round_d = 4'd10;
            rcon_d  = 8'h36;
`endif
        end else if (state_q == ACTIVE && next) begin
            if (round_q == 4'd0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                round_d = round_q - 4'd1;
`ifdef AES_KEY_REV_256_EN
                if (len_q) begin
                    // At round 1 lo already holds rk0, so it is only shifted into hi.
                    hi_d = lo_q;
                    if (round_q >= 4'd2) begin
                        lo_d = {c0, c1, c2, c3};
                    end
                    if (even_rnd) begin
                        rcon_d = rcon_back(rcon_q);
                    end
                end else begin
                    hi_d   = {c0, c1, c2, c3};
                    rcon_d = rcon_back(rcon_q);
                end
`else
                hi_d   = {c0, c1, c2, c3};
                rcon_d = rcon_back(rcon_q);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hi_q    <= '0;
            round_q <= '0;
            rcon_q  <= '0;
            done_q  <= 1'b0;
`ifdef AES_KEY_REV_256_EN
            lo_q    <= '0;
            len_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
`ifdef AES_KEY_REV_256_EN
            lo_q    <= lo_d;
            len_q   <= len_d;
`endif
        end
    end

    assign round_key = hi_q;
    assign round     = round_q;
    assign valid     = (state_q == ACTIVE);
    assign done      = done_q;

endmodule

// File: tb/tb_aes_key_rev_gen.sv
// Directed bench for aes_key_rev_gen using FIPS-197 key expansion vectors and a behavioural S-box.
module tb_aes_key_rev_gen;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [255:0] key = '0;
    logic         keylen = 1'b0;
    logic         load = 1'b0;
    logic         next = 1'b0;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic         valid;
    logic         done;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [127:0] rk [0:10];

    aes_key_rev_gen dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key       (key),
        .keylen    (keylen),
        .load      (load),
        .next      (next),
        .round_key (round_key),
        .round     (round),
        .valid     (valid),
        .done      (done),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv, s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    always_comb begin
        new_sboxw = {sbox(sboxw[31:24]), sbox(sboxw[23:16]), sbox(sboxw[15:8]), sbox(sboxw[7:0])};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset state
        tick();
        tick();
        check("rst_key", round_key, 128'h0);
        check("rst_round", {124'h0, round}, 128'h0);
        check("rst_valid", {127'h0, valid}, 128'h0);
        check("rst_done", {127'h0, done}, 128'h0);
        check("rst_sboxw", {96'h0, sboxw}, 128'h0);

        // next while idle is ignored
        reset_n = 1'b1;
        tick();
        next = 1'b1;
        tick();
        next = 1'b0;
        tick();
        check("idle_next_key", round_key, 128'h0);
        check("idle_next_valid", {127'h0, valid}, 128'h0);
        check("idle_next_round", {124'h0, round}, 128'h0);

        // AES-128 load and single-pulse stepping
        key = {rk[10], 128'h0};
        keylen = 1'b0;
        load = 1'b1;
        tick();
        load = 1'b0;
        check("load_valid", {127'h0, valid}, 128'h1);
        check("load_round", {124'h0, round}, 128'd10);
        check("load_key", round_key, rk[10]);
        check("load_sboxw", {96'h0, sboxw}, {96'h0, 32'h575c006e});
        for (int k = 9; k >= 0; k--) begin
            next = 1'b1;
            tick();
            next = 1'b0;
            tick();
            check($sformatf("pulse_round%0d", k), {124'h0, round}, 128'(k));
            check($sformatf("pulse_key%0d", k), round_key, rk[k]);
        end
        next = 1'b1;
        tick();
        next = 1'b0;
        check("end_valid", {127'h0, valid}, 128'h0);
        check("end_done", {127'h0, done}, 128'h1);
        check("end_key_hold", round_key, rk[0]);
        tick();
        check("end_done_pulse", {127'h0, done}, 128'h0);
        next = 1'b1;
        tick();
        next = 1'b0;
        tick();
        check("idle2_valid", {127'h0, valid}, 128'h0);
        check("idle2_key", round_key, rk[0]);

        // Back-to-back stepping with next held high
        load = 1'b1;
        tick();
        load = 1'b0;
        next = 1'b1;
        for (int k = 9; k >= 0; k--) begin
            tick();
            check($sformatf("b2b_round%0d", k), {124'h0, round}, 128'(k));
            check($sformatf("b2b_key%0d", k), round_key, rk[k]);
        end
        tick();
        next = 1'b0;
        check("b2b_done", {127'h0, done}, 128'h1);
        check("b2b_valid", {127'h0, valid}, 128'h0);

        // load coincident with next wins
        load = 1'b1;
        tick();
        load = 1'b0;
        next = 1'b1;
        tick();
        tick();
        tick();
        check("mid_round7", {124'h0, round}, 128'd7);
        load = 1'b1;
        tick();
        load = 1'b0;
        next = 1'b0;
        check("coinc_round", {124'h0, round}, 128'd10);
        check("coinc_key", round_key, rk[10]);

        // Asynchronous reset mid-sequence, then a fresh full sequence
        next = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        next = 1'b0;
        check("pre_rst_round", {124'h0, round}, 128'd5);
        check("pre_rst_key", round_key, rk[5]);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_key", round_key, 128'h0);
        check("arst_round", {124'h0, round}, 128'h0);
        check("arst_valid", {127'h0, valid}, 128'h0);
        tick();
        reset_n = 1'b1;
        tick();
        load = 1'b1;
        tick();
        load = 1'b0;
        check("reload_key", round_key, rk[10]);
        next = 1'b1;
        for (int k = 9; k >= 0; k--) begin
            tick();
            check($sformatf("reload_key%0d", k), round_key, rk[k]);
        end
        next = 1'b0;
        tick();

`ifdef AES_KEY_REV_256_EN
        // AES-256 FIPS-197 vector
        key = {128'hfe4890d1e6188d0b046df344706c631e, 128'h24fc79ccbf0979e9371ac23c6d68de36};
        keylen = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        keylen = 1'b0;
        check("a256_round14", {124'h0, round}, 128'd14);
        check("a256_key14", round_key, 128'hfe4890d1e6188d0b046df344706c631e);
        next = 1'b1;
        tick();
        check("a256_key13", round_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        for (int k = 0; k < 12; k++) tick();
        check("a256_round1", {124'h0, round}, 128'd1);
        check("a256_key1", round_key, 128'h1f352c073b6108d72d9810a30914dff4);
        tick();
        check("a256_round0", {124'h0, round}, 128'd0);
        check("a256_key0", round_key, 128'h603deb1015ca71be2b73aef0857d7781);
        tick();
        next = 1'b0;
        check("a256_done", {127'h0, done}, 128'h1);
`else
        // keylen is ignored in an AES-128-only build
        key = {rk[10], 128'h24fc79ccbf0979e9371ac23c6d68de36};
        keylen = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        keylen = 1'b0;
        check("k128_only_round", {124'h0, round}, 128'd10);
        next = 1'b1;
        tick();
        next = 1'b0;
        check("k128_only_key9", round_key, rk[9]);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
